// File: rtl/wb_port_arbiter_3_if.sv
// Write-back arbiter bus: request/payload bundle from the pipeline stages and the
// registered grant/write-port outputs towards the register file.
interface wb_port_arbiter_3_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              stall;
    logic [2:0]        req;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] wdata2;
    logic [ADDR_W-1:0] waddr0;
    logic [ADDR_W-1:0] waddr1;
    logic [ADDR_W-1:0] waddr2;
    logic [2:0]        gnt;
    logic [1:0]        sel;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output stall, req, wdata0, wdata1, wdata2, waddr0, waddr1, waddr2,
        input  gnt, sel, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  stall, req, wdata0, wdata1, wdata2, waddr0, waddr1, waddr2,
        output gnt, sel, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_port_arbiter_3.sv
// Round-robin arbiter for the single register-file write port shared by the
// ALU result (0), load data (1) and link/PC+4 (2) requesters.
module wb_port_arbiter_3 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_port_arbiter_3_if.slave   bus
);

    function automatic logic [1:0] inc_mod3(input logic [1:0] v);
        case (v)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] v);
        case (v)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    logic [1:0]        ptr_r;
    logic [1:0]        ptr_s;
    logic [1:0]        cand0_s;
    logic [1:0]        cand1_s;
    logic [1:0]        cand2_s;
    logic [2:0]        eff_s;
    logic              win_valid_s;
    logic [1:0]        win_s;
    logic [DATA_W-1:0] win_data_s;
    logic [ADDR_W-1:0] win_addr_s;

    // Winner search from the pointer with the just-granted requester masked out;
    // a corrupted pointer value of 3 is searched as if it were 0.
    always_comb begin
        ptr_s       = (ptr_r == 2'd3) ? 2'd0 : ptr_r;
        cand0_s     = ptr_s;
        cand1_s     = inc_mod3(cand0_s);
        cand2_s     = inc_mod3(cand1_s);
        eff_s       = bus.req & ~bus.gnt;
        win_valid_s = 1'b1;
        win_s       = 2'd0;
        if (eff_s[cand0_s]) begin
            win_s = cand0_s;
        end else if (eff_s[cand1_s]) begin
            win_s = cand1_s;
        end else if (eff_s[cand2_s]) begin
            win_s = cand2_s;
        end else begin
            win_valid_s = 1'b0;
        end
    end

    // Write-back payload mux driven by the winner index.
    always_comb begin
        case (win_s)
            2'd0: begin
                win_data_s = bus.wdata0;
                win_addr_s = bus.waddr0;
            end
            2'd1: begin
                win_data_s = bus.wdata1;
                win_addr_s = bus.waddr1;
            end
            default: begin
                win_data_s = bus.wdata2;
                win_addr_s = bus.waddr2;
            end
        endcase
    end

    // Registered grant, select and write port; stall or no winner only kills the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.gnt      <= 3'b000;
            bus.sel      <= 2'b00;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= {ADDR_W{1'b0}};
            bus.rf_wdata <= {DATA_W{1'b0}};
            ptr_r        <= 2'd0;
        end else if (!bus.stall && win_valid_s) begin
            bus.gnt      <= onehot3(win_s);
            bus.sel      <= win_s;
            bus.rf_we    <= (win_addr_s != {ADDR_W{1'b0}});
            bus.rf_waddr <= win_addr_s;
            bus.rf_wdata <= win_data_s;
            ptr_r        <= inc_mod3(win_s);
        end else begin
            bus.gnt      <= 3'b000;
            bus.rf_we    <= 1'b0;
        end
    end

endmodule
